// File: rtl/ballot_collector.sv
// Ballot collector: gathers one vote per voter over valid/ready, flags duplicate
// and out-of-range IDs, and issues the assembled vote vector over valid/ack.
module ballot_collector #(
    parameter int PERSON  = 6,
    parameter int IDW     = 3,
    parameter int TIMEOUT = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              vote_valid,
    input  logic [IDW-1:0]    vote_id,
    input  logic              vote_val,
    output logic              vote_ready,
    output logic              dup_err,
    output logic              bad_id_err,
    output logic [PERSON-1:0] ballot,
    output logic [PERSON-1:0] ballot_mask,
    output logic [IDW:0]      yes_cnt,
    output logic              ballot_valid,
    input  logic              ballot_ack,
    output logic              timed_out,
    output logic              busy
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, ISSUE} state_t;

    state_t            state;
    state_t            state_next;
    logic [TW-1:0]     timer;
    logic [IDW:0]      voted;
    logic [PERSON-1:0] id_onehot;
    logic              id_bad;
    logic              id_dup;
    logic              accept;
    logic              complete;
    logic              timeout_hit;

    // Decode the voter ID into a one-hot select; out-of-range IDs decode to zero.
    always_comb begin
        id_onehot = '0;
        for (int i = 0; i < PERSON; i++) begin
            if (vote_id == IDW'(i)) begin
                id_onehot[i] = 1'b1;
            end
        end
    end

    assign id_bad      = ({1'b0, vote_id} >= (IDW+1)'(PERSON));
    assign id_dup      = |(id_onehot & ballot_mask);
    assign accept      = vote_valid && vote_ready && !id_bad && !id_dup;
    assign complete    = accept && (voted == (IDW+1)'(PERSON - 1));
    assign timeout_hit = (TIMEOUT != 0) && (timer == TW'(TIMEOUT - 1));

    assign vote_ready   = (state == COLLECT);
    assign ballot_valid = (state == ISSUE);
    assign busy         = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = COLLECT;
            COLLECT: if (complete || timeout_hit) state_next = ISSUE;
            ISSUE:   if (ballot_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Round datapath: cleared on start, updated only by accepted ballots.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ballot      <= '0;
            ballot_mask <= '0;
            yes_cnt     <= '0;
            voted       <= '0;
            timer       <= '0;
            timed_out   <= 1'b0;
            dup_err     <= 1'b0;
            bad_id_err  <= 1'b0;
        end else begin
            dup_err    <= 1'b0;
            bad_id_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ballot      <= '0;
                        ballot_mask <= '0;
                        yes_cnt     <= '0;
                        voted       <= '0;
                        timer       <= '0;
                        timed_out   <= 1'b0;
                    end
                end
                COLLECT: begin
                    timer <= timer + 1'b1;
                    if (vote_valid && id_bad) begin
                        bad_id_err <= 1'b1;
                    end else if (vote_valid && id_dup) begin
                        dup_err <= 1'b1;
                    end
                    if (accept) begin
                        ballot      <= (ballot & ~id_onehot) | (vote_val ? id_onehot : '0);
                        ballot_mask <= ballot_mask | id_onehot;
                        yes_cnt     <= yes_cnt + {{IDW{1'b0}}, vote_val};
                        voted       <= voted + 1'b1;
                    end
                    if (timeout_hit && !complete) begin
                        timed_out <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ballot_collector.sv
// Directed bench for ballot_collector: reset, full rounds, error pulses,
// timeout, completion/timeout tie and a stalled ISSUE handshake.
module tb_ballot_collector;

    logic       clk;
    logic       reset;
    logic       start;
    logic       vote_valid;
    logic [2:0] vote_id;
    logic       vote_val;
    logic       vote_ready;
    logic       dup_err;
    logic       bad_id_err;
    logic [5:0] ballot;
    logic [5:0] ballot_mask;
    logic [3:0] yes_cnt;
    logic       ballot_valid;
    logic       ballot_ack;
    logic       timed_out;
    logic       busy;

    int checks = 0;
    int errors = 0;

    ballot_collector #(.PERSON(6), .IDW(3), .TIMEOUT(100)) dut (
        .clk(clk), .reset(reset), .start(start),
        .vote_valid(vote_valid), .vote_id(vote_id), .vote_val(vote_val),
        .vote_ready(vote_ready), .dup_err(dup_err), .bad_id_err(bad_id_err),
        .ballot(ballot), .ballot_mask(ballot_mask), .yes_cnt(yes_cnt),
        .ballot_valid(ballot_valid), .ballot_ack(ballot_ack),
        .timed_out(timed_out), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [2:0] id, input logic val);
        vote_valid = 1'b1;
        vote_id    = id;
        vote_val   = val;
        tick();
        vote_valid = 1'b0;
    endtask

    task automatic startRound();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic ackRound();
        ballot_ack = 1'b1;
        tick();
        ballot_ack = 1'b0;
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, "_busy"},   busy, 0);
        checkOutput({tag, "_ballot"}, ballot, 0);
        checkOutput({tag, "_mask"},   ballot_mask, 0);
        checkOutput({tag, "_yes"},    yes_cnt, 0);
        checkOutput({tag, "_valid"},  ballot_valid, 0);
        checkOutput({tag, "_ready"},  vote_ready, 0);
        checkOutput({tag, "_tout"},   timed_out, 0);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        vote_valid = 1'b0;
        vote_id    = 3'd0;
        vote_val   = 1'b0;
        ballot_ack = 1'b0;
        #2 reset = 1'b0;
        tick();
        checkIdleZero("por");
        reset = 1'b1;
        tick();

        // Reset mid-COLLECT after three votes clears everything at once
        startRound();
        checkOutput("t1_ready", vote_ready, 1);
        applyStimulus(3'd0, 1'b1);
        applyStimulus(3'd1, 1'b1);
        applyStimulus(3'd2, 1'b1);
        checkOutput("t1_mask3", ballot_mask, 6'b000111);
        #2 reset = 1'b0;
        #1 checkIdleZero("t1_rst");
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Full round: ids 0..5, votes 1,0,1,1,0,1
        startRound();
        applyStimulus(3'd0, 1'b1);
        applyStimulus(3'd1, 1'b0);
        applyStimulus(3'd2, 1'b1);
        applyStimulus(3'd3, 1'b1);
        applyStimulus(3'd4, 1'b0);
        checkOutput("t2_valid5", ballot_valid, 0);
        checkOutput("t2_yes5", yes_cnt, 3);
        applyStimulus(3'd5, 1'b1);
        checkOutput("t2_ballot", ballot, 6'b101101);
        checkOutput("t2_mask", ballot_mask, 6'h3F);
        checkOutput("t2_yes", yes_cnt, 4);
        checkOutput("t2_valid", ballot_valid, 1);
        checkOutput("t2_tout", timed_out, 0);
        checkOutput("t2_ready", vote_ready, 0);
        ackRound();
        checkOutput("t2_valid_ack", ballot_valid, 0);
        checkOutput("t2_busy_ack", busy, 0);
        checkOutput("t2_hold", ballot, 6'b101101);

        // Duplicate and out-of-range ballots, including back-to-back offences
        startRound();
        checkOutput("t3_cleared", ballot_mask, 0);
        applyStimulus(3'd2, 1'b1);
        applyStimulus(3'd2, 1'b0);
        checkOutput("t3_dup", dup_err, 1);
        checkOutput("t3_b2", ballot, 6'b000100);
        checkOutput("t3_yes", yes_cnt, 1);
        tick();
        checkOutput("t3_dup_drop", dup_err, 0);
        applyStimulus(3'd7, 1'b1);
        checkOutput("t3_bad", bad_id_err, 1);
        checkOutput("t3_dup_quiet", dup_err, 0);
        checkOutput("t3_mask", ballot_mask, 6'b000100);
        vote_valid = 1'b1;
        vote_id    = 3'd6;
        tick();
        checkOutput("t3_bad_b2b1", bad_id_err, 1);
        tick();
        checkOutput("t3_bad_b2b2", bad_id_err, 1);
        vote_valid = 1'b0;
        tick();
        checkOutput("t3_bad_drop", bad_id_err, 0);
        checkOutput("t3_mask2", ballot_mask, 6'b000100);
        applyStimulus(3'd0, 1'b0);
        applyStimulus(3'd1, 1'b0);
        applyStimulus(3'd3, 1'b0);
        applyStimulus(3'd4, 1'b0);
        applyStimulus(3'd5, 1'b0);
        checkOutput("t3_valid", ballot_valid, 1);
        checkOutput("t3_final", ballot, 6'b000100);
        checkOutput("t3_final_yes", yes_cnt, 1);
        ackRound();

        // Timeout: two votes then silence; ISSUE 100 edges after start
        startRound();
        applyStimulus(3'd0, 1'b1);
        applyStimulus(3'd1, 1'b1);
        repeat (97) tick();
        checkOutput("t4_pre", ballot_valid, 0);
        tick();
        checkOutput("t4_valid", ballot_valid, 1);
        checkOutput("t4_tout", timed_out, 1);
        checkOutput("t4_mask", ballot_mask, 6'b000011);
        checkOutput("t4_ballot", ballot, 6'b000011);
        checkOutput("t4_yes", yes_cnt, 2);
        ackRound();
        checkOutput("t4_idle", busy, 0);

        // Sixth vote lands on the timeout edge: completion wins
        startRound();
        checkOutput("t5_tout_clr", timed_out, 0);
        for (int i = 0; i < 5; i++) applyStimulus(3'(i), 1'b1);
        repeat (94) tick();
        checkOutput("t5_pre", ballot_valid, 0);
        applyStimulus(3'd5, 1'b1);
        checkOutput("t5_valid", ballot_valid, 1);
        checkOutput("t5_mask", ballot_mask, 6'h3F);
        checkOutput("t5_tout", timed_out, 0);
        checkOutput("t5_yes", yes_cnt, 6);

        // Stalled ISSUE: ack low for 20 cycles with start and stray ballots
        start      = 1'b1;
        vote_valid = 1'b1;
        vote_id    = 3'd7;
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput("t6_valid", ballot_valid, 1);
            checkOutput("t6_ready", vote_ready, 0);
            checkOutput("t6_ballot", ballot, 6'h3F);
            checkOutput("t6_bad", bad_id_err, 0);
        end
        start      = 1'b0;
        vote_valid = 1'b0;
        ackRound();
        checkOutput("t6_valid_ack", ballot_valid, 0);
        checkOutput("t6_busy_ack", busy, 0);
        vote_valid = 1'b1;
        vote_id    = 3'd0;
        vote_val   = 1'b0;
        tick();
        vote_valid = 1'b0;
        checkOutput("t6_idle_ignore", ballot, 6'h3F);
        checkOutput("t6_idle_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
